gpio_ctrl: RTL and testbench

GPIO_CTRL -- requirements
Module: gpio_ctrl

---
 rtl/gpio_ctrl.sv | 131 +++++++++++++
 tb/tb_gpio_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_ctrl.sv
// GPIO controller: single-cycle-ack register bus, per-pin direction/output,
// synchronized inputs with rising/falling edge interrupts (W1C pending bits).
module gpio_ctrl #(
  parameter int unsigned NGPIO = 8
) (
  input  logic             sys_clk_i,
  input  logic             rstn_i,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [2:0]       addr_i,
  input  logic [31:0]      wdata_i,
  output logic             ack_o,
  output logic [31:0]      rdata_o,
  output logic [NGPIO-1:0] gpio_dir_o,
  output logic [NGPIO-1:0] gpio_val_o,
  input  logic [NGPIO-1:0] gpio_val_i,
  output logic             irq_o
);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    REG_DIR      = 3'd0,
    REG_OUT      = 3'd1,
    REG_IN       = 3'd2,
    REG_IRQ_EN   = 3'd3,
    REG_IRQ_EDGE = 3'd4,
    REG_IRQ_PEND = 3'd5
  } reg_addr_t;

  state_t           state_q, state_d;
  logic             xfer;
  logic [NGPIO-1:0] wd;
  logic [31:0]      rd_mux;
  logic [31:0]      rdata_q;

  logic [NGPIO-1:0] dir_q, out_q, en_q, edge_q, pend_q;
  logic [NGPIO-1:0] sync1_q, sync2_q, prev_q;
  logic [NGPIO-1:0] rise, fall, pend_set, pend_clr;
  logic [1:0]       settle_q;
  logic             settled;
  logic             irq_q;
  logic             unused_wdata;

  assign wd           = wdata_i[NGPIO-1:0];
  assign unused_wdata = ^wdata_i;

  always_ff @(posedge sys_clk_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    xfer    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = ACK;
          xfer    = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (addr_i)
      REG_DIR:      rd_mux[NGPIO-1:0] = dir_q;
      REG_OUT:      rd_mux[NGPIO-1:0] = out_q;
      REG_IN:       rd_mux[NGPIO-1:0] = sync2_q;
      REG_IRQ_EN:   rd_mux[NGPIO-1:0] = en_q;
      REG_IRQ_EDGE: rd_mux[NGPIO-1:0] = edge_q;
      REG_IRQ_PEND: rd_mux[NGPIO-1:0] = pend_q;
      default:      rd_mux = '0;
    endcase
  end

  // Edges are ignored until the synchronizer and prev flops have refilled
  // after reset, so pins already high at reset do not look like rising edges.
  assign settled  = (settle_q == 2'd3);
  assign rise     = sync2_q & ~prev_q;
  assign fall     = ~sync2_q & prev_q;
  assign pend_set = settled ? (en_q & dir_q & ((edge_q & rise) | (~edge_q & fall))) : '0;
  assign pend_clr = (xfer && we_i && addr_i == REG_IRQ_PEND) ? wd : '0;

  always_ff @(posedge sys_clk_i) begin
    if (!rstn_i) begin
      dir_q    <= '1;
      out_q    <= '0;
      en_q     <= '0;
      edge_q   <= '0;
      pend_q   <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      settle_q <= '0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (xfer && we_i) begin
        case (addr_i)
          REG_DIR:      dir_q  <= wd;
          REG_OUT:      out_q  <= wd;
          REG_IRQ_EN:   en_q   <= wd;
          REG_IRQ_EDGE: edge_q <= wd;
          default:      ;
        endcase
      end
      sync1_q  <= gpio_val_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      if (!settled) settle_q <= settle_q + 2'd1;
      pend_q   <= (pend_q & ~pend_clr) | pend_set;
      irq_q    <= |(pend_q & en_q);
      rdata_q  <= xfer ? rd_mux : '0;
    end
  end

  assign ack_o      = (state_q == ACK);
  assign rdata_o    = rdata_q;
  assign gpio_dir_o = dir_q;
  assign gpio_val_o = out_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a pin-history based reference model.
module tb_gpio_ctrl;

  localparam int unsigned N = 8;

  logic          sys_clk;
  logic          rstn;
  logic          req;
  logic          we;
  logic [2:0]    addr;
  logic [31:0]   wdata;
  logic          ack_o;
  logic [31:0]   rdata_o;
  logic [N-1:0]  gpio_dir_o;
  logic [N-1:0]  gpio_val_o;
  logic [N-1:0]  pins;
  logic          irq_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  bit          chk_en  = 1'b0;

  gpio_ctrl #(.NGPIO(N)) dut (
    .sys_clk_i  (sys_clk),
    .rstn_i     (rstn),
    .req_i      (req),
    .we_i       (we),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .ack_o      (ack_o),
    .rdata_o    (rdata_o),
    .gpio_dir_o (gpio_dir_o),
    .gpio_val_o (gpio_val_o),
    .gpio_val_i (pins),
    .irq_o      (irq_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: register values, a history of pin samples taken each
  // clock, and a count of clocks since reset.
  logic [N-1:0] m_dir = '1, m_out = '0, m_en = '0, m_edge = '0, m_pend = '0;
  logic [N-1:0] hist[$];
  int unsigned  m_cyc = 0;
  bit           m_busy = 1'b0;
  logic         m_ack = 1'b0, m_irq = 1'b0;
  logic [31:0]  m_rdata = '0;
  logic [N-1:0] m_sync, m_prev, m_set, m_clr;
  logic [31:0]  m_rd;

  always @(posedge sys_clk) begin
    if (!rstn) begin
      m_dir = '1; m_out = '0; m_en = '0; m_edge = '0; m_pend = '0;
      hist = {8'h00, 8'h00, 8'h00};
      m_cyc = 0; m_busy = 1'b0; m_ack = 1'b0; m_irq = 1'b0; m_rdata = '0;
    end else begin
      // pins seen by IN are those sampled two clocks back; prev is three back
      m_sync = hist[hist.size()-2];
      m_prev = hist[hist.size()-3];
      m_irq  = |(m_pend & m_en);
      m_set  = '0;
      if (m_cyc >= 3)
        for (int i = 0; i < N; i++)
          if (m_en[i] && m_dir[i] && m_sync[i] != m_prev[i] && m_sync[i] == m_edge[i])
            m_set[i] = 1'b1;
      m_clr = '0;
      if (!m_busy && req) begin
        case (addr)
          3'd0: m_rd = {24'h0, m_dir};
          3'd1: m_rd = {24'h0, m_out};
          3'd2: m_rd = {24'h0, m_sync};
          3'd3: m_rd = {24'h0, m_en};
          3'd4: m_rd = {24'h0, m_edge};
          3'd5: m_rd = {24'h0, m_pend};
          default: m_rd = '0;
        endcase
        if (we)
          case (addr)
            3'd0: m_dir  = wdata[N-1:0];
            3'd1: m_out  = wdata[N-1:0];
            3'd3: m_en   = wdata[N-1:0];
            3'd4: m_edge = wdata[N-1:0];
            3'd5: m_clr  = wdata[N-1:0];
            default: ;
          endcase
        m_busy = 1'b1; m_ack = 1'b1; m_rdata = m_rd;
      end else begin
        m_busy = 1'b0; m_ack = 1'b0; m_rdata = '0;
      end
      m_pend = (m_pend & ~m_clr) | m_set;
      hist.push_back(pins);
      if (hist.size() > 4) void'(hist.pop_front());
      if (m_cyc < 3) m_cyc++;
    end
  end

  always @(negedge sys_clk) begin
    if (chk_en) begin
      check_val("ack",   32'(ack_o),      32'(m_ack));
      check_val("rdata", rdata_o,         m_rdata);
      check_val("dir",   32'(gpio_dir_o), 32'(m_dir));
      check_val("out",   32'(gpio_val_o), 32'(m_out));
      check_val("irq",   32'(irq_o),      32'(m_irq));
    end
  end

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic xfer(input logic w, input logic [2:0] a, input logic [31:0] d,
                      output logic [31:0] r);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge sys_clk); #1;
    check_val("ack_lat", 32'(ack_o), 32'd1);
    r = rdata_o;
    req = 1'b0; we = 1'b0;
    @(posedge sys_clk); #1;
    check_val("ack_drop", 32'(ack_o), 32'd0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step(2);
    rstn = 1'b1;
  endtask

  logic [31:0] rd;
  int unsigned acks;

  initial begin
    rstn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; pins = '0;
    @(posedge sys_clk); #1;
    chk_en = 1'b1;
    step(2);
    rstn = 1'b1;

    // reset values
    xfer(1'b0, 3'd0, '0, rd); check_val("rst_dir",  rd, 32'hFF);
    xfer(1'b0, 3'd1, '0, rd); check_val("rst_out",  rd, 32'h00);
    xfer(1'b0, 3'd2, '0, rd); check_val("rst_in",   rd, 32'h00);
    xfer(1'b0, 3'd3, '0, rd); check_val("rst_en",   rd, 32'h00);
    xfer(1'b0, 3'd4, '0, rd); check_val("rst_edge", rd, 32'h00);
    xfer(1'b0, 3'd5, '0, rd); check_val("rst_pend", rd, 32'h00);

    // outputs follow DIR/OUT; unmapped reads 0; upper write bits dropped
    xfer(1'b1, 3'd0, 32'hFFFF_FF0F, rd);
    xfer(1'b1, 3'd1, 32'h0000_00A5, rd);
    check_val("pin_dir", 32'(gpio_dir_o), 32'h0F);
    check_val("pin_out", 32'(gpio_val_o), 32'hA5);
    xfer(1'b1, 3'd7, 32'h1234_5678, rd); check_val("unmapped_wr", rd, 32'h0);
    xfer(1'b0, 3'd7, '0, rd);            check_val("unmapped_rd", rd, 32'h0);
    xfer(1'b0, 3'd0, '0, rd);            check_val("dir_upper0",  rd, 32'h0F);

    // input synchronizer latency
    pins = 8'h3C;
    xfer(1'b0, 3'd2, '0, rd); check_val("in_old", rd, 32'h00);
    xfer(1'b0, 3'd2, '0, rd); check_val("in_new", rd, 32'h3C);
    xfer(1'b1, 3'd2, 32'hFF, rd);
    xfer(1'b0, 3'd2, '0, rd); check_val("in_ro",  rd, 32'h3C);

    // rising-edge interrupt on pin 0 only
    pins = 8'h00; step(4);
    xfer(1'b1, 3'd0, 32'hFF, rd);
    xfer(1'b1, 3'd3, 32'h01, rd);
    xfer(1'b1, 3'd4, 32'h01, rd);
    pins = 8'h01; step(5);
    xfer(1'b0, 3'd5, '0, rd); check_val("pend_set", rd, 32'h01);
    check_val("irq_set", 32'(irq_o), 32'd1);
    pins = 8'h03; step(5);
    xfer(1'b0, 3'd5, '0, rd); check_val("pend_pin1", rd, 32'h01);
    xfer(1'b1, 3'd5, 32'h01, rd);
    step(1);
    check_val("irq_clr", 32'(irq_o), 32'd0);
    // disabling IRQ_EN keeps the pending bit
    pins = 8'h02; step(4);
    pins = 8'h03; step(5);
    xfer(1'b1, 3'd3, 32'h00, rd);
    xfer(1'b0, 3'd5, '0, rd); check_val("pend_keep", rd, 32'h01);
    xfer(1'b1, 3'd5, 32'h01, rd);
    xfer(1'b1, 3'd3, 32'h01, rd);

    // W1C colliding with a fresh rising edge: set wins
    pins = 8'h02; step(5);
    pins = 8'h03; step(2);
    xfer(1'b1, 3'd5, 32'h01, rd);
    xfer(1'b0, 3'd5, '0, rd); check_val("set_wins", rd, 32'h01);

    // back-to-back requests
    acks = 0;
    req = 1'b1; we = 1'b0; addr = 3'd1;
    for (int i = 0; i < 6; i++) begin
      @(posedge sys_clk); #1;
      if (ack_o) acks++;
    end
    req = 1'b0;
    check_val("b2b_acks", acks, 32'd3);

    // reset during ACK aborts and restores defaults
    req = 1'b1; we = 1'b1; addr = 3'd1; wdata = 32'h55;
    @(posedge sys_clk); #1;
    req = 1'b0; we = 1'b0; rstn = 1'b0;
    @(posedge sys_clk); #1;
    rstn = 1'b1;
    check_val("rst_ack",   32'(ack_o),      32'd0);
    check_val("rst_pdir",  32'(gpio_dir_o), 32'hFF);
    check_val("rst_pout",  32'(gpio_val_o), 32'h00);
    check_val("rst_irq",   32'(irq_o),      32'd0);

    // pins high across reset must not set pending bits
    pins = 8'hFF;
    do_reset();
    xfer(1'b1, 3'd3, 32'hFF, rd);
    xfer(1'b1, 3'd4, 32'hFF, rd);
    step(3);
    xfer(1'b0, 3'd5, '0, rd); check_val("rst_noedge", rd, 32'h00);

    // randomized traffic
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      if ($urandom_range(0, 2) == 0) pins = N'($urandom);
      step($urandom_range(0, 3));
      req = 1'b1;
      we = 1'($urandom);
      addr = 3'($urandom_range(0, 7));
      wdata = $urandom;
      if (addr == 3'd5 && $urandom_range(0, 1) == 1) wdata = '0;
      @(posedge sys_clk); #1;
      if ($urandom_range(0, 3) != 0) begin
        req = 1'b0;
        we = 1'b0;
      end
      @(posedge sys_clk); #1;
      req = 1'b0;
      we = 1'b0;
    end
    step(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
